// File: rtl/acc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// acc_ctrl_fsm
//
// Multicycle control FSM for the 16-bit accumulator processor. Each
// instruction is sequenced through FETCH, DECODE, an optional memory phase
// (MEMRD / MEMWR) and an optional EXEC phase. The FSM drives the ALU operand
// selects, the ALU operation, the register write enables and the memory
// read/write handshake. A watchdog on the memory handshake sends the FSM to
// an absorbing FAULT state if memory never answers.
//
// Parameters
//   MAX_WAIT      cycles a memory request may wait for mem_ready (>= 1)
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   instr_op      in   [3:0] IR[15:12], valid from DECODE until the next
//                      fetch completes
//   acc_zero      in   accumulator == 0 flag (used by BEQZ)
//   mem_ready     in   memory completes the current access this cycle
//   alu_src_a     out  [1:0] 0=ACC 1=const 8 2=PC 3=MDR
//   alu_src_b     out  [1:0] 0=sext IMM12 1=MDR 2=ACC 3=const 2
//   alu_op        out  [1:0] 0=ADD 1=SUB 2=PASSA 3=SLL (B << A[3:0])
//   mem_addr_sel  out  address select, 0=PC 1=IR[11:0]
//   mem_read      out  read request, held until mem_ready
//   mem_write     out  write request (data = ACC), held until mem_ready
//   ir_write      out  load IR from memory data
//   mdr_write     out  load MDR from memory data
//   pc_write      out  load PC from ALU result
//   acc_write     out  load ACC from ALU result
//   halted        out  FSM is in HALT
//   fault         out  FSM is in FAULT (memory timeout)
//   illegal       out  one-cycle pulse in DECODE for an undefined opcode
// ---------------------------------------------------------------------------
module acc_ctrl_fsm #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] instr_op,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_addr_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic       acc_write,
    output logic       halted,
    output logic       fault,
    output logic       illegal
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEMRD  = 3'd3;
    localparam logic [2:0] S_MEMWR  = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // Opcodes (IR[15:12]); 8..14 are undefined and execute as NOP
    localparam logic [3:0] OP_ADDI  = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_BEQZ  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_SLL8  = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // ALU source A select
    localparam logic [1:0] SRC_A_ACC  = 2'd0;
    localparam logic [1:0] SRC_A_C8   = 2'd1;
    localparam logic [1:0] SRC_A_PC   = 2'd2;
    localparam logic [1:0] SRC_A_MDR  = 2'd3;

    // ALU source B select
    localparam logic [1:0] SRC_B_IMM  = 2'd0;
    localparam logic [1:0] SRC_B_MDR  = 2'd1;
    localparam logic [1:0] SRC_B_ACC  = 2'd2;
    localparam logic [1:0] SRC_B_C2   = 2'd3;

    // ALU operation
    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_PASSA  = 2'd2;
    localparam logic [1:0] ALU_SLL    = 2'd3;

    // The wait counter only ever holds 0 .. MAX_WAIT-1.
    localparam int          CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic [3:0]    op_q,    op_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic in_mem_wait;
    logic timeout;

    // A memory-handshake state is stalled when mem_ready is low. The last
    // permitted stall cycle diverts to FAULT; mem_ready on that same cycle
    // still completes the access normally.
    assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    assign timeout     = in_mem_wait && !mem_ready && (cnt_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        // The counter is zero unless we are staying in a stalled memory
        // state; this clears it on entry to every handshake state and
        // whenever mem_ready completes an access.
        cnt_d   = '0;
        if (in_mem_wait && !mem_ready && !timeout) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                // Keep the opcode so EXEC does not depend on instr_op.
                op_d = instr_op;
                case (instr_op)
                    OP_ADD, OP_SUB, OP_LOAD: state_d = S_MEMRD;
                    OP_STORE:                state_d = S_MEMWR;
                    OP_ADDI, OP_SLL8:        state_d = S_EXEC;
                    OP_HALT:                 state_d = S_HALT;
                    // BEQZ/JMP finish here; undefined opcodes act as NOP
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_EXEC;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (state + latched opcode + mem_ready)
    // -----------------------------------------------------------------------
    always_comb begin
        alu_src_a    = SRC_A_ACC;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        mem_addr_sel = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        acc_write    = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Read the instruction at PC and advance PC by the constant
                // 2 in the same cycle the memory completes.
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_C2;
                alu_op    = ALU_ADD;
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                case (instr_op)
                    OP_BEQZ: begin
                        alu_src_a = SRC_A_PC;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                        pc_write  = acc_zero;
                    end
                    OP_JMP: begin
                        alu_src_a = SRC_A_PC;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                        pc_write  = 1'b1;
                    end
                    OP_ADDI, OP_ADD, OP_SUB, OP_LOAD,
                    OP_STORE, OP_SLL8, OP_HALT: begin
                        // Defined opcodes with nothing to drive in DECODE.
                    end
                    default: begin
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                mem_addr_sel = 1'b1;
                mem_read     = 1'b1;
                mdr_write    = mem_ready;
            end
            S_MEMWR: begin
                mem_addr_sel = 1'b1;
                mem_write    = 1'b1;
            end
            S_EXEC: begin
                acc_write = 1'b1;
                case (op_q)
                    OP_ADD: begin
                        alu_src_a = SRC_A_ACC;
                        alu_src_b = SRC_B_MDR;
                        alu_op    = ALU_ADD;
                    end
                    OP_SUB: begin
                        alu_src_a = SRC_A_ACC;
                        alu_src_b = SRC_B_MDR;
                        alu_op    = ALU_SUB;
                    end
                    OP_LOAD: begin
                        alu_src_a = SRC_A_MDR;
                        alu_op    = ALU_PASSA;
                    end
                    OP_SLL8: begin
                        // ACC << 8: shift amount comes from port A.
                        alu_src_a = SRC_A_C8;
                        alu_src_b = SRC_B_ACC;
                        alu_op    = ALU_SLL;
                    end
                    default: begin
                        // ADDI
                        alu_src_a = SRC_A_ACC;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                // RST: everything stays at zero.
            end
        endcase
    end

endmodule
